memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255 (range 1..255), max cycles BUSY waits for memory_valid.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_enable / req1_enable  input  1 each  requester issues a transaction (port 0 = core controller, port 1 = debug/DMA).
REQ-005 req0_command / req1_command  input  1 each  0 = read, 1 = write.
REQ-006 req0_address / req1_address  input  32 each  byte address.
REQ-007 req0_write_data / req1_write_data  input  32 each  store data.
REQ-008 req0_store_type / req1_store_type  input  2 each  store encoder type.
REQ-009 req0_ready / req1_ready  output  1 each  port may issue this cycle.
REQ-010 req0_valid / req1_valid  output  1 each  transaction complete, read data valid.
REQ-011 req0_error / req1_error  output  1 each  one-cycle timeout pulse.
REQ-012 req0_read_data / req1_read_data  output  32 each  memory_read_data, qualified by reqN_valid.
REQ-013 memory_ready  input  1; memory_valid  input  1; memory_read_data  input  32.
REQ-014 memory_enable  output  1; memory_command  output  1; memory_address  output  32; memory_write_data  output  32; memory_store_type  output  2.
REQ-015 busy  output  1 (state BUSY); owner  output  1 (port of current/last transaction).

Function
REQ-016 States: IDLE, BUSY; one outstanding transaction at most.
REQ-017 In IDLE with memory_ready=1, grant goes to the single requesting port; with both requesting, per REQ-034/035.
REQ-018 reqN_ready = IDLE & memory_ready & grant==N; combinational; 0 in BUSY.
REQ-019 Acceptance: reqN_enable & reqN_ready; same cycle memory_enable=1 and memory_command/address/write_data/store_type driven from port N.
REQ-020 No acceptance: memory_enable=0; memory_* data outputs don't-care.
REQ-021 Acceptance latches owner=N, clears timeout counter, enters BUSY next cycle.
REQ-022 memory_valid in the acceptance cycle: zero-wait completion, reqN_valid=1 that cycle, stay IDLE.
REQ-023 BUSY: memory_valid=1 -> req<owner>_valid=1 same cycle, read data routed, IDLE next cycle.
REQ-024 BUSY: counter increments per cycle without memory_valid; on reaching TIMEOUT_CYCLES, req<owner>_error=1 for that cycle, IDLE next cycle.
REQ-025 memory_valid and timeout in same cycle: valid wins, no error.
REQ-026 memory_valid in IDLE without acceptance ignored (late response after timeout dropped).
REQ-027 Non-owner valid/error/ready held 0 throughout BUSY.
REQ-028 Counter 8 bits; saturation impossible (leaves BUSY at TIMEOUT_CYCLES).
REQ-029 Back-to-back: grant re-evaluated in the first IDLE cycle after completion; no extra idle cycle.

Reset
REQ-030 reset_n=0 asynchronously forces IDLE, owner=0, last_grant=1, counter=0.
REQ-031 During reset, all outputs 0 except read_data buses (don't-care).
REQ-032 Reset mid-BUSY abandons transaction; no valid/error pulse; late memory_valid after release ignored per REQ-026.
REQ-033 First edge after deassertion behaves as IDLE.

Configuration
REQ-034 MEMORY_ARBITER_ROUND_ROBIN_EN defined: both requesting -> grant to port != last_grant; last_grant updated on each acceptance; first contest after reset goes to port 0.
REQ-035 Undefined: fixed priority, port 0 always wins a contest; last_grant unused.

Verification
REQ-036 Port 0 read 0x100, memory_valid 3 cycles after enable -> req0_valid 1 cycle, data 0xDEADBEEF, busy 3 cycles, req1_ready 0 throughout.
REQ-037 Both request every cycle, zero-wait memory, ROUND_ROBIN_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-038 TIMEOUT_CYCLES=4, no memory_valid -> req1_error pulse 4 cycles after acceptance, then IDLE; memory_valid 2 cycles later -> no reqN_valid.
REQ-039 memory_ready=0 with req0_enable=1 -> req0_ready=0, memory_enable=0; ready rises -> acceptance same cycle.
REQ-040 reset_n low 2 cycles mid-BUSY -> busy=0 immediately, no valid/error; next request accepted normally.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between two requesters, the shared memory port and the arbiter.
// slave  : arbiter view (takes requests, drives grants, responses and memory side)
// master : environment view (requesters plus memory model)
interface memory_arbiter_if;
  logic        req0_enable,     req1_enable;
  logic        req0_command,    req1_command;
  logic [31:0] req0_address,    req1_address;
  logic [31:0] req0_write_data, req1_write_data;
  logic [1:0]  req0_store_type, req1_store_type;
  logic        req0_ready,      req1_ready;
  logic        req0_valid,      req1_valid;
  logic        req0_error,      req1_error;
  logic [31:0] req0_read_data,  req1_read_data;

  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] memory_read_data;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [1:0]  memory_store_type;

  logic        busy;
  logic        owner;

  modport slave (
    input  req0_enable, req1_enable, req0_command, req1_command,
           req0_address, req1_address, req0_write_data, req1_write_data,
           req0_store_type, req1_store_type,
           memory_ready, memory_valid, memory_read_data,
    output req0_ready, req1_ready, req0_valid, req1_valid,
           req0_error, req1_error, req0_read_data, req1_read_data,
           memory_enable, memory_command, memory_address,
           memory_write_data, memory_store_type, busy, owner
  );

  modport master (
    output req0_enable, req1_enable, req0_command, req1_command,
           req0_address, req1_address, req0_write_data, req1_write_data,
           req0_store_type, req1_store_type,
           memory_ready, memory_valid, memory_read_data,
    input  req0_ready, req1_ready, req0_valid, req1_valid,
           req0_error, req1_error, req0_read_data, req1_read_data,
           memory_enable, memory_command, memory_address,
           memory_write_data, memory_store_type, busy, owner
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-outstanding memory port.
// One transaction in flight at most; BUSY waits for memory_valid up to
// TIMEOUT_CYCLES, then pulses the owner's error and returns to IDLE.
// Optional build macro MEMORY_ARBITER_ROUND_ROBIN_EN: contested grants
// alternate between ports; without it port 0 always wins a contest.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  memory_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Counter value seen in the last BUSY cycle allowed to wait.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic [7:0]  r_count;
  logic        w_grant;
  logic        w_rdy0;
  logic        w_rdy1;
  logic        w_accept;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic        r_last_grant;

  // Contest goes to the port that did not win the previous acceptance.
  always_comb begin
    if (bus.req0_enable && bus.req1_enable) w_grant = ~r_last_grant;
    else                                    w_grant = bus.req1_enable;
  end

  // Remember the winner of every acceptance; reset makes port 0 win first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_grant;
  end
`else
  // Fixed priority: port 1 is granted only when port 0 is not asking.
  always_comb begin
    w_grant = bus.req1_enable & ~bus.req0_enable;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Owner latch and wait counter; counter restarts on every acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= 1'b0;
      r_count <= 8'd0;
    end else if (w_accept) begin
      r_owner <= w_grant;
      r_count <= 8'd0;
    end else if (r_state == S_BUSY && !bus.memory_valid) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Next state, grant handshake, memory request and per-port responses.
  // Everything is forced low while reset_n is asserted.
  always_comb begin
    w_state_nxt           = r_state;
    w_rdy0                = 1'b0;
    w_rdy1                = 1'b0;
    w_accept              = 1'b0;
    bus.memory_enable     = 1'b0;
    bus.memory_command    = 1'b0;
    bus.memory_address    = 32'd0;
    bus.memory_write_data = 32'd0;
    bus.memory_store_type = 2'd0;
    bus.req0_valid        = 1'b0;
    bus.req1_valid        = 1'b0;
    bus.req0_error        = 1'b0;
    bus.req1_error        = 1'b0;
    bus.busy              = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IDLE: begin
          w_rdy0   = bus.memory_ready & ~w_grant;
          w_rdy1   = bus.memory_ready &  w_grant;
          w_accept = (w_rdy0 & bus.req0_enable) | (w_rdy1 & bus.req1_enable);
          if (w_accept) begin
            bus.memory_enable     = 1'b1;
            bus.memory_command    = w_grant ? bus.req1_command    : bus.req0_command;
            bus.memory_address    = w_grant ? bus.req1_address    : bus.req0_address;
            bus.memory_write_data = w_grant ? bus.req1_write_data : bus.req0_write_data;
            bus.memory_store_type = w_grant ? bus.req1_store_type : bus.req0_store_type;
            // Zero-wait completion stays in IDLE.
            if (bus.memory_valid) begin
              bus.req0_valid = ~w_grant;
              bus.req1_valid =  w_grant;
            end else begin
              w_state_nxt = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          bus.busy = 1'b1;
          // A response arriving on the timeout cycle still counts as success.
          if (bus.memory_valid) begin
            bus.req0_valid = ~r_owner;
            bus.req1_valid =  r_owner;
            w_state_nxt    = S_IDLE;
          end else if (r_count == LP_LAST_WAIT) begin
            bus.req0_error = ~r_owner;
            bus.req1_error =  r_owner;
            w_state_nxt    = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    bus.req0_ready = w_rdy0;
    bus.req1_ready = w_rdy1;
  end

  assign bus.req0_read_data = bus.memory_read_data;
  assign bus.req1_read_data = bus.memory_read_data;
  assign bus.owner          = r_owner;

endmodule
